// File: rtl/card_shuffle_dealer.sv
// Card shoe: fills NUM_DECKS*52 card indices, Fisher-Yates shuffles them with a
// Galois LFSR (rejection sampling), then deals single cards or runs a dealer auto-draw.
module card_shuffle_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'h0014,
  parameter int          STAND_AT  = 16,
  localparam int         DECK_SIZE = 52 * NUM_DECKS,
  localparam int         W         = $clog2(DECK_SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shuffle_start,
  input  logic         deal_req,
  input  logic         dealer_start,
  input  logic [4:0]   dealer_init,
  output logic         ready,
  output logic         card_valid,
  output logic [5:0]   card_id,
  output logic [3:0]   card_value,
  output logic [W:0]   cards_left,
  output logic         deck_empty,
  output logic         dealer_busy,
  output logic         dealer_done,
  output logic [4:0]   dealer_total,
  output logic         dealer_bust
);

  localparam logic [15:0]  LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [W-1:0] LAST      = W'(DECK_SIZE - 1);
  localparam logic [W:0]   FULL      = (W+1)'(DECK_SIZE);
  localparam logic [5:0]   STAND     = 6'(STAND_AT);

  typedef enum logic [2:0] {IDLE, FILL, SHUFFLE, READY, DRAW} state_t;
  state_t state, state_nx;

  logic [W-1:0] deck [DECK_SIZE];
  logic [15:0]  lfsr;
  logic [W-1:0] k, i, p, r;
  logic [W-1:0] cur;
  logic [5:0]   cur_id;
  logic [3:0]   cur_rank, cur_val;
  logic [5:0]   sum;
  logic [4:0]   tot_nx;
  logic         draw_last;
  logic         do_shuf, do_swap, do_card, do_dstart, do_dquick, do_dend;

  // Card currently at the deal pointer, and the dealer total if it were drawn.
  always_comb begin
    r         = lfsr[W-1:0];
    cur       = deck[p];
    cur_id    = 6'(cur % W'(52));
    cur_rank  = 4'(cur_id % 6'd13);
    cur_val   = (cur_rank >= 4'd9) ? 4'd10 : cur_rank + 4'd1;
    sum       = {1'b0, dealer_total} + {2'b0, cur_val};
    tot_nx    = sum[5] ? 5'd31 : sum[4:0];
    draw_last = ({1'b0, tot_nx} >= STAND) || (cards_left == (W+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_shuf   = 1'b0;
    do_swap   = 1'b0;
    do_card   = 1'b0;
    do_dstart = 1'b0;
    do_dquick = 1'b0;
    do_dend   = 1'b0;
    case (state)
      IDLE: if (shuffle_start) begin
        state_nx = FILL;
        do_shuf  = 1'b1;
      end
      FILL: if (k == LAST) state_nx = SHUFFLE;
      SHUFFLE: if (r <= i) begin
        do_swap = 1'b1;
        if (i == W'(1)) state_nx = READY;
      end
      READY: begin
        if (shuffle_start) begin
          state_nx = FILL;
          do_shuf  = 1'b1;
        end else if (dealer_start) begin
          // A dealer already at its stand total finishes without entering DRAW.
          if ({1'b0, dealer_init} >= STAND) begin
            do_dquick = 1'b1;
          end else begin
            do_dstart = 1'b1;
            state_nx  = DRAW;
          end
        end else if (deal_req && cards_left != '0) begin
          do_card = 1'b1;
        end
      end
      DRAW: begin
        if (cards_left == '0) begin
          do_dend  = 1'b1;
          state_nx = READY;
        end else begin
          do_card = 1'b1;
          if (draw_last) begin
            do_dend  = 1'b1;
            state_nx = READY;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr         <= LFSR_INIT;
      k            <= '0;
      i            <= '0;
      p            <= '0;
      cards_left   <= '0;
      card_valid   <= 1'b0;
      card_id      <= '0;
      card_value   <= '0;
      dealer_done  <= 1'b0;
      dealer_total <= '0;
      dealer_bust  <= 1'b0;
    end else begin
      lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      card_valid  <= 1'b0;
      dealer_done <= 1'b0;
      if (do_shuf) begin
        k          <= '0;
        p          <= '0;
        cards_left <= '0;
      end
      if (state == FILL) begin
        k <= k + 1'b1;
        if (k == LAST) i <= LAST;
      end
      if (do_swap) begin
        i <= i - 1'b1;
        if (i == W'(1)) begin
          p          <= '0;
          cards_left <= FULL;
        end
      end
      if (do_card) begin
        card_valid <= 1'b1;
        card_id    <= cur_id;
        card_value <= cur_val;
        p          <= p + 1'b1;
        cards_left <= cards_left - 1'b1;
        if (state == DRAW) dealer_total <= tot_nx;
      end
      if (do_dstart) begin
        dealer_total <= dealer_init;
        dealer_bust  <= 1'b0;
      end
      if (do_dquick) begin
        dealer_total <= dealer_init;
        dealer_done  <= 1'b1;
        dealer_bust  <= (dealer_init > 5'd21);
      end
      if (do_dend) begin
        dealer_done <= 1'b1;
        dealer_bust <= (cards_left == '0) ? (dealer_total > 5'd21) : (tot_nx > 5'd21);
      end
    end
  end

  // Shoe storage has no reset; its contents are rebuilt by every FILL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FILL) begin
        deck[k] <= k;
      end else if (do_swap) begin
        deck[i] <= deck[r];
        deck[r] <= deck[i];
      end
    end
  end

  assign ready       = (state == READY);
  assign deck_empty  = ready && (cards_left == '0);
  assign dealer_busy = (state == DRAW);

endmodule

// File: tb/tb_card_shuffle_dealer.sv
// Scoreboard bench: a Fisher-Yates shoe model predicts every card and dealer result;
// monitors pop and compare on card_valid / dealer_done.
module tb_card_shuffle_dealer;
  localparam int DS = 52;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       shuffle_start, deal_req, dealer_start;
  logic [4:0] dealer_init;
  logic       ready, card_valid, deck_empty, dealer_busy, dealer_done, dealer_bust;
  logic [5:0] card_id;
  logic [3:0] card_value;
  logic [6:0] cards_left;
  logic [4:0] dealer_total;

  logic       sh2, dr2, rdy2, cv2, empty2, busy2, done2, bust2;
  logic [5:0] id2;
  logic [3:0] val2;
  logic [7:0] left2;
  logic [4:0] tot2;

  card_shuffle_dealer #(.NUM_DECKS(1)) dut (
    .clk(clk), .reset(reset), .shuffle_start(shuffle_start), .deal_req(deal_req),
    .dealer_start(dealer_start), .dealer_init(dealer_init), .ready(ready),
    .card_valid(card_valid), .card_id(card_id), .card_value(card_value),
    .cards_left(cards_left), .deck_empty(deck_empty), .dealer_busy(dealer_busy),
    .dealer_done(dealer_done), .dealer_total(dealer_total), .dealer_bust(dealer_bust)
  );

  card_shuffle_dealer #(.NUM_DECKS(2)) dut2 (
    .clk(clk), .reset(reset), .shuffle_start(sh2), .deal_req(dr2),
    .dealer_start(1'b0), .dealer_init(5'd0), .ready(rdy2),
    .card_valid(cv2), .card_id(id2), .card_value(val2),
    .cards_left(left2), .deck_empty(empty2), .dealer_busy(busy2),
    .dealer_done(done2), .dealer_total(tot2), .dealer_bust(bust2)
  );

  int cmp = 0;
  int err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {int id; int val; int left;} card_t;
  typedef struct {int total; int bust;} dres_t;
  card_t exp_q[$];
  dres_t dexp_q[$];
  int    log_q[$];
  int    n_seen = 0;
  int    shoe[DS];
  int    mp = 0;
  int    mleft = 0;
  int    ncyc = 0;
  int    tally2[64];
  int    n2 = 0;

  always @(posedge clk) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int cval(input int id);
    return (id % 13 >= 9) ? 10 : id % 13 + 1;
  endfunction

  // Shuffle sampled at the edge whose lfsr is SEED stepped c times; returns the
  // non-reset edge count at which ready is first observable.
  function automatic int model_shuffle(input int c);
    logic [15:0] x;
    int i, m, r, t;
    x = 16'h0014;
    for (int n = 0; n < c + DS + 1; n++) x = lstep(x);
    for (int n = 0; n < DS; n++) shoe[n] = n;
    i = DS - 1;
    m = c + DS + 1;
    while (i >= 1) begin
      r = int'(x[5:0]);
      if (r <= i) begin
        t = shoe[i]; shoe[i] = shoe[r]; shoe[r] = t;
        i--;
      end
      x = lstep(x);
      m++;
    end
    mp = 0;
    mleft = DS;
    return m;
  endfunction

  always @(negedge clk) begin : mon
    card_t e;
    dres_t d;
    if (card_valid) begin
      n_seen++;
      log_q.push_back(int'(card_id));
      if (exp_q.size() == 0) chk("unexpected_card", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("card_id", int'(card_id), e.id);
        chk("card_value", int'(card_value), e.val);
        chk("cards_left", int'(cards_left), e.left);
      end
    end
    if (dealer_done) begin
      if (dexp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = dexp_q.pop_front();
        chk("dealer_total", int'(dealer_total), d.total);
        chk("dealer_bust", int'(dealer_bust), d.bust);
      end
    end
  end

  always @(negedge clk) begin : mon2
    if (cv2) begin
      n2++;
      tally2[id2]++;
      chk("d2_value", int'(val2), cval(int'(id2)));
    end
  end

  task automatic do_shuffle();
    int c, m, k;
    @(negedge clk); shuffle_start = 1'b1; c = ncyc;
    @(negedge clk); shuffle_start = 1'b0;
    m = model_shuffle(c);
    k = 0;
    while (!ready && k < 4096) begin @(negedge clk); k++; end
    chk("ready_timeout", int'(ready), 1);
    chk("ready_cycle", ncyc, m);
    chk("full_shoe", int'(cards_left), DS);
  endtask

  task automatic deal(input int n, input int gap_max);
    card_t e;
    for (int j = 0; j < n; j++) begin
      @(negedge clk); deal_req = 1'b1;
      if (mleft > 0) begin
        mleft--;
        e.id = shoe[mp] % 52; e.val = cval(e.id); e.left = mleft;
        exp_q.push_back(e);
        mp++;
      end
      if (gap_max > 0 && $urandom_range(0, 1) == 1) begin
        @(negedge clk); deal_req = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    @(negedge clk); deal_req = 1'b0;
  endtask

  task automatic dealer(input int init, input bit with_deal);
    int total, k, id;
    bit got;
    card_t e;
    dres_t d;
    @(negedge clk);
    dealer_start = 1'b1; dealer_init = 5'(init); deal_req = with_deal;
    total = init;
    if (init < 16) begin
      while (mleft > 0) begin
        id = shoe[mp] % 52;
        total += cval(id);
        if (total > 31) total = 31;
        mleft--;
        e.id = id; e.val = cval(id); e.left = mleft;
        exp_q.push_back(e);
        mp++;
        if (total >= 16) break;
      end
    end
    d.total = total; d.bust = int'(total > 21);
    dexp_q.push_back(d);
    @(negedge clk); dealer_start = 1'b0; deal_req = 1'b0;
    if (init >= 16) chk("done_latency", int'(dealer_done), 1);
    else            chk("busy_not_ready", int'(dealer_busy && !ready), 1);
    got = dealer_done; k = 0;
    while (!got && k < 300) begin @(negedge clk); got = dealer_done; k++; end
    chk("dealer_done_timeout", int'(got), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cmp=%0d err=%0d", cmp, err);
    $fatal(1);
  end

  initial begin
    int d0, ok, k;
    int seq1[$];
    int tally[64];
    shuffle_start = 0; deal_req = 0; dealer_start = 0; dealer_init = 0;
    sh2 = 0; dr2 = 0;
    foreach (tally2[t]) tally2[t] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({ready, card_valid, cards_left, deck_empty, dealer_busy,
        dealer_done, dealer_total, dealer_bust, card_id, card_value}), 0);

    d0 = $urandom_range(0, 15);
    reset = 1'b0;
    repeat (d0) @(negedge clk);
    chk("idle_not_ready", int'(ready), 0);
    do_shuffle();
    log_q.delete();
    deal(DS, 2);
    repeat (2) @(negedge clk);
    chk("empty_left", int'(cards_left), 0);
    chk("deck_empty", int'(deck_empty), 1);
    foreach (tally[t]) tally[t] = 0;
    foreach (log_q[j]) tally[log_q[j]]++;
    ok = int'(log_q.size() == DS);
    for (int t = 0; t < DS; t++) if (tally[t] != 1) ok = 0;
    chk("perm_once", ok, 1);
    seq1 = log_q;
    deal(1, 0);
    repeat (3) @(negedge clk);
    chk("no_53rd_card", n_seen, DS);
    chk("still_empty", int'(deck_empty), 1);

    do_shuffle();
    dealer(12, 1'b0);
    dealer(18, 1'b1);
    deal(3, 1);
    repeat (12) begin
      case ($urandom_range(0, 2))
        0: deal($urandom_range(1, 6), 2);
        1: dealer($urandom_range(4, 20), 1'($urandom_range(0, 1)));
        default: if (mleft < 20) do_shuffle(); else deal(2, 0);
      endcase
    end
    // Drain the shoe so the dealer runs out of cards, then starts on an empty shoe.
    do_shuffle();
    deal(mleft - 2, 0);
    dealer(2, 1'b0);
    dealer(5, 1'b0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a shuffle, then replay the first run.
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (d0) @(negedge clk);
    @(negedge clk); shuffle_start = 1'b1;
    @(negedge clk); shuffle_start = 1'b0;
    repeat (60) @(negedge clk);
    chk("shuffling_not_ready", int'(ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", int'({ready, card_valid, cards_left, deck_empty, dealer_busy,
        dealer_done, dealer_total, dealer_bust, card_id, card_value}), 0);
    reset = 1'b0;
    repeat (d0) @(negedge clk);
    do_shuffle();
    log_q.delete();
    deal(DS, 1);
    repeat (2) @(negedge clk);
    ok = int'(log_q.size() == seq1.size());
    foreach (log_q[j]) if (j < seq1.size() && log_q[j] != seq1[j]) ok = 0;
    chk("replay_same_sequence", ok, 1);

    // Two-deck shoe: every id exactly twice.
    @(negedge clk); sh2 = 1'b1;
    @(negedge clk); sh2 = 1'b0;
    k = 0;
    while (!rdy2 && k < 4096) begin @(negedge clk); k++; end
    chk("d2_ready_timeout", int'(rdy2), 1);
    chk("d2_full_shoe", int'(left2), 2 * DS);
    dr2 = 1'b1;
    k = 0;
    while (n2 < 2 * DS && k < 300) begin @(negedge clk); k++; end
    dr2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("d2_card_count", n2, 2 * DS);
    ok = 1;
    for (int t = 0; t < DS; t++) if (tally2[t] != 2) ok = 0;
    chk("d2_each_twice", ok, 1);
    chk("d2_deck_empty", int'(empty2), 1);

    chk("scoreboard_drained", exp_q.size() + dexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/card_shuffle_dealer.md
CARD_SHUFFLE_DEALER -- requirements
Module: card_shuffle_dealer

Interface
REQ-001 SHALL have parameter NUM_DECKS, default 1 (legal 1..4): number of 52-card decks in the shoe.
REQ-002 SHALL have parameter SEED, default 16'h0014: LFSR reset value; SEED==0 SHALL be replaced by 16'hACE1.
REQ-003 SHALL have parameter STAND_AT, default 16: dealer stops drawing once its total is >= STAND_AT.
REQ-004 SHALL derive DECK_SIZE = 52*NUM_DECKS and W = clog2(DECK_SIZE).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 shuffle_start  in  1  pulse that starts a fill+shuffle of the shoe.
REQ-009 deal_req  in  1  request one card.
REQ-010 dealer_start  in  1  start dealer auto-draw.
REQ-011 dealer_init  in  5  dealer starting total, sampled on dealer_start.
REQ-012 ready  out  1  shoe shuffled, idle, accepting requests.
REQ-013 card_valid  out  1  one-cycle pulse: card_id/card_value valid.
REQ-014 card_id  out  6  0..51; suit = id/13, rank = id%13.
REQ-015 card_value  out  4  rank+1 capped at 10 (ace=1).
REQ-016 cards_left  out  W+1  undealt cards.
REQ-017 deck_empty  out  1  cards_left==0 while ready.
REQ-018 dealer_busy  out  1  auto-draw in progress.
REQ-019 dealer_done  out  1  one-cycle pulse at auto-draw end.
REQ-020 dealer_total  out  5  final or running dealer total.
REQ-021 dealer_bust  out  1  dealer_total > 21, valid with dealer_done, held until next dealer_start.

Function
REQ-022 SHALL hold the shoe in a register array deck[0..DECK_SIZE-1] of W-bit indices; card_id = deck[k] % 52.
REQ-023 SHALL run a 16-bit Galois LFSR, mask 16'hB400, advancing every cycle outside reset.
REQ-024 States SHALL be IDLE, FILL, SHUFFLE, READY and DRAW.
REQ-025 IDLE: shuffle_start -> FILL; all other inputs ignored.
REQ-026 FILL: writes deck[k]=k, one entry per cycle, k=0..DECK_SIZE-1 (DECK_SIZE cycles), then SHUFFLE with i=DECK_SIZE-1.
REQ-027 SHUFFLE: r = lfsr[W-1:0] each cycle.
REQ-028 SHUFFLE: if r<=i, swap deck[i] and deck[r] in the same cycle and decrement i; else reject and retry next cycle.
REQ-029 SHUFFLE: after the swap with i==1, enter READY next cycle with ready=1, cards_left=DECK_SIZE and deal pointer p=0.
REQ-030 READY, deal_req with cards_left>0: next cycle card_valid=1 and card outputs from deck[p]; p increments and cards_left decrements. Latency is 1 cycle; back-to-back requests give one card per cycle.
REQ-031 READY, deal_req with cards_left==0: no card_valid; deck_empty stays 1.
REQ-032 READY, dealer_start: load dealer_total=dealer_init and go to DRAW with dealer_busy=1, ready=0.
REQ-033 If dealer_init>=STAND_AT, draw no cards and pulse dealer_done on the next cycle.
REQ-034 DRAW: one card per cycle, each reported via card_valid.
REQ-035 DRAW: dealer_total += card_value (aces=1), saturating at 31.
REQ-036 DRAW: stop when total>=STAND_AT or cards_left==0.
REQ-037 DRAW end: pulse dealer_done, drive dealer_busy=0, set dealer_bust=(total>21), return to READY.
REQ-038 Priority in READY: shuffle_start > dealer_start > deal_req; lower-priority requests in the same cycle are dropped, not queued.
REQ-039 shuffle_start in READY or IDLE SHALL restart FILL; it SHALL be ignored in FILL, SHUFFLE and DRAW.
REQ-040 Requests outside READY SHALL be ignored; ready=0 outside READY.
REQ-041 Same SEED and same input sequence SHALL give an identical card sequence.

Reset
REQ-042 Reset SHALL force IDLE and lfsr=SEED (or 16'hACE1 if SEED==0), and clear all outputs, i and p to 0.
REQ-043 Reset mid-FILL, mid-SHUFFLE or mid-DRAW SHALL abort the operation with no card_valid or dealer_done pulse; deck contents are don't-care until the next FILL.

Verification
REQ-044 NUM_DECKS=1: reset, shuffle_start -> ready within 4096 cycles; 52 deal_req -> 52 card_valid, ids 0..51 each exactly once, cards_left 52->0, deck_empty=1; 53rd deal_req -> no card_valid.
REQ-045 NUM_DECKS=2: full deal -> each id 0..51 appears exactly twice; card_value matches id%13 map (0->1, 9->10, 12->10, 13->1).
REQ-046 dealer_init=12 -> dealer_done once; dealer_total>=16 and equals 12+sum of reported card_values; dealer_bust==(total>21).
REQ-047 dealer_init=18 -> dealer_done next cycle, no card_valid, total 18, bust 0; deal_req+dealer_start same cycle -> dealer wins, no extra card.
REQ-048 Reset asserted mid-SHUFFLE -> all outputs 0 next cycle; re-shuffle gives a sequence identical to the first run after reset.
